// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, line levels and parity sense.
// The receiver imports this package too.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Edge/bit counter for the transmitter: edge counter wraps every presc cycles,
// bit counter indexes data bits while the FSM is in its data phase.
module uart_tx_baud_cnt #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               run,
    input  logic               data_phase,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_done,
    output logic               last_bit
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
    localparam logic [BIT_W-1:0]   BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]   LAST_IDX  = BIT_W'(DATA_WIDTH - 1);

    logic [PRESC_W-1:0] edge_cnt_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;

    // presc is never 0 while run is high: the core clamps it on acceptance.
    assign bit_done = run && (edge_cnt_reg == (presc - PRESC_ONE));
    assign last_bit = (bit_cnt_reg == LAST_IDX);

    always_ff @(posedge clk) begin
        if (srst) begin
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            if (!run || bit_done) begin
                edge_cnt_reg <= '0;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + PRESC_ONE;
            end

            if (!data_phase) begin
                bit_cnt_reg <= '0;
            end else if (bit_done) begin
                bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop.
// Every bit lasts Prescale clocks; TX_OUT and busy are registered.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);
    tx_state_t             state_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_reg;
    logic                  parity_reg;
    logic [PRESC_W-1:0]    presc_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  bit_done;
    logic                  last_bit;

    uart_tx_baud_cnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESC_W    (PRESC_W)
    ) u_baud_cnt (
        .clk        (CLK),
        .srst       (RST),
        .run        (state_reg != ST_IDLE),
        .data_phase (state_reg == ST_DATA),
        .presc      (presc_reg),
        .bit_done   (bit_done),
        .last_bit   (last_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            shift_reg  <= '0;
            par_en_reg <= 1'b0;
            parity_reg <= 1'b0;
            presc_reg  <= '0;
            tx_reg     <= UART_IDLE_LVL;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg   <= UART_IDLE_LVL;
                    busy_reg <= 1'b0;
                    if (Data_Valid) begin
                        shift_reg  <= P_DATA;
                        par_en_reg <= PAR_EN;
                        parity_reg <= (^P_DATA) ^ PAR_TYP;
                        presc_reg  <= (Prescale == '0) ? PRESC_W'(1) : Prescale;
                        state_reg  <= ST_START;
                        tx_reg     <= UART_START_LVL;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // The shift register always presents the next data bit at [0].
                    if (bit_done) begin
                        if (last_bit) begin
                            if (par_en_reg) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= parity_reg;
                            end else begin
                                state_reg <= ST_STOP;
                                tx_reg    <= UART_STOP_LVL;
                            end
                        end else begin
                            tx_reg    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        state_reg <= ST_STOP;
                        tx_reg    <= UART_STOP_LVL;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        state_reg <= ST_IDLE;
                        tx_reg    <= UART_IDLE_LVL;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= UART_IDLE_LVL;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Frame transmitter for the UART link; the transmit counterpart of the existing oversampled receiver.
- Accepts a parallel byte with a one-cycle valid strobe.
- Serializes it LSB-first as start, data, optional parity, stop on a single line.
- Each bit is held for Prescale clock cycles, so TX and RX share one CLK and one Prescale setting.
- Parity convention matches the receiver: PAR_TYP 0 = even, 1 = odd.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESC_W, 6, width of Prescale input (bit period in CLK cycles)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  byte to send, sampled on acceptance
Data_Valid  input  1  request strobe; accepted only when busy=0
PAR_EN  input  1  1 = insert parity bit, sampled on acceptance
PAR_TYP  input  1  0 = even, 1 = odd, sampled on acceptance
Prescale  input  PRESC_W  CLK cycles per bit, sampled on acceptance
TX_OUT  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset:
  - TX_OUT=1, busy=0, FSM=IDLE, counters and data shift register cleared.
  - RST wins over every other input on the same edge.
  - RST mid-frame aborts the frame: TX_OUT=1 and busy=0 from the next edge; the latched byte is discarded.
- Registered outputs: TX_OUT and busy are registers; no combinational path from inputs to outputs.
- Acceptance:
  - Occurs on an edge where FSM=IDLE, RST=0 and Data_Valid=1.
  - Latches P_DATA, PAR_EN, PAR_TYP and Prescale.
  - Computes parity = ^P_DATA XOR PAR_TYP.
  - Next cycle: FSM=START, TX_OUT=0, busy=1.
  - Latency from accepting edge to start-bit edge is 1 cycle.
- Data_Valid while busy=1 is ignored; there is no queueing and no error flag.
- Prescale:
  - Legal range 1..63; latched value 0 is treated as 1.
  - Later changes to Prescale do not affect a frame in flight.
- Edge counter: counts 0..Prescale-1 within each bit and wraps to 0 at the bit boundary.
- Bit counter: indexes data bits 0..DATA_WIDTH-1.
- FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE: TX_OUT=1, busy=0. Go to START on acceptance.
  - START: TX_OUT=0 for Prescale cycles, then DATA with bit index 0.
  - DATA: TX_OUT = data[bit index], held Prescale cycles. After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT = latched parity, held Prescale cycles, then STOP.
  - STOP: TX_OUT=1 for Prescale cycles, then IDLE. busy=0 from the first IDLE cycle.
- Frame length:
  - (DATA_WIDTH+2)*Prescale cycles without parity.
  - (DATA_WIDTH+3)*Prescale cycles with parity.
- Back-to-back frames:
  - Data_Valid held high continuously gives one IDLE cycle (the acceptance cycle, TX_OUT=1) between frames.
  - Minimum frame-to-frame period is frame length + 1.
- TX_OUT never glitches: it changes only at bit boundaries and on reset.

Decomposition:
Shared package uart_pkg holds:
- FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits.
- Constants UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1.
- PAR_EVEN=0, PAR_ODD=1, also used by the receiver's parity check.

One natural sub-module, uart_tx_baud_cnt:
- Contains the edge counter and bit counter with a bit_done pulse.
- Mirrors the receiver's edge/bit counter.
- The FSM, shift register and parity live in uart_tx_core.

Test Plan:
1. Prescale=8, PAR_EN=0, P_DATA=0xA5, one Data_Valid pulse.
   -> TX_OUT per 8-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   -> busy high exactly 80 cycles, starting the cycle after acceptance.
2. Prescale=8, PAR_EN=1, P_DATA=0xA5 sent twice, first with PAR_TYP=0, then with PAR_TYP=1.
   -> Even case: parity bit = 0.
   -> Odd case: parity bit = 1.
   -> 88-cycle frames; a loopback through the receiver gives P_DATA=0xA5, data_valid=1, no parity error.
3. Data_Valid held high with P_DATA=0x3C then 0xC3, Prescale=16, no parity.
   -> Two frames of 160 cycles separated by exactly one idle-high cycle.
   -> Data_Valid pulses during busy are ignored.
4. Start 0xFF at Prescale=8, assert RST for 1 cycle in DATA bit 3.
   -> Next edge TX_OUT=1, busy=0.
   -> A new Data_Valid (0x00) afterwards sends a clean, complete frame.
5. Change Prescale 8->32 and P_DATA mid-frame.
   -> The current frame keeps 8-cycle bits and the original byte.
   -> The next accepted frame uses 32-cycle bits.
6. Prescale=0 and Prescale=1, P_DATA=0x01.
   -> Both give 1-cycle bits: TX_OUT sequence 0,1,0,0,0,0,0,0,0,1, busy high 10 cycles.
